// File: rtl/cic_decimator.sv
// cic_decimator: dual-channel CIC decimation filter placed after the mixer.
// Ports: clk, rst (synchronous, active-high); sinewave_in/cosinewave_in
//   (signed, valid every cycle); sine_decim_out/cosine_decim_out (signed,
//   reduced rate); decim_valid (one-cycle strobe marking new outputs).
// Option: define CIC_ROUND_EN to round (with positive saturation) before the
//   output slice; left undefined, the output stage truncates.
module cic_decimator #(
   parameter int DATA_WIDTH = 12,
   parameter int CIC_ORDER  = 3,
   parameter int DECIMATION = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] sinewave_in,
   input  logic [DATA_WIDTH-1:0] cosinewave_in,
   output logic [DATA_WIDTH-1:0] sine_decim_out,
   output logic [DATA_WIDTH-1:0] cosine_decim_out,
   output logic                  decim_valid
);

   localparam int CW    = $clog2(DECIMATION);
   localparam int ACC_W = DATA_WIDTH + CIC_ORDER * CW;
   localparam int SH    = ACC_W - DATA_WIDTH;
`ifdef CIC_ROUND_EN
   localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SH - 1);
   localparam logic [DATA_WIDTH-1:0] MAXP = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif

   // Index 0 is the sine channel, index 1 the cosine channel.
   logic [DATA_WIDTH-1:0] x_in   [2];
   logic [ACC_W-1:0]      x_q    [2];
   logic [ACC_W-1:0]      int_q  [2][CIC_ORDER];
   logic [ACC_W-1:0]      cap_q  [2];
   logic [ACC_W-1:0]      c_q    [2][CIC_ORDER];
   logic [ACC_W-1:0]      d_q    [2][CIC_ORDER];
   logic [ACC_W-1:0]      cmb_in [2][CIC_ORDER];
   logic [DATA_WIDTH-1:0] out_q  [2];
   logic [DATA_WIDTH-1:0] out_d  [2];
`ifdef CIC_ROUND_EN
   logic [ACC_W:0]        rnd    [2];
`endif

   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic                 dec_strobe;
   // Bit 0 captures the integrator, bits 1..ORDER step the combs,
   // the top bit loads the output register.
   logic [CIC_ORDER+1:0] stb_q;
   logic                 valid_q;

   assign dec_strobe = (cnt_q == CW'(DECIMATION - 1));
   assign cnt_d      = dec_strobe ? '0 : cnt_q + CW'(1);

   always_comb begin
      x_in[0] = sinewave_in;
      x_in[1] = cosinewave_in;
      for (int ch = 0; ch < 2; ch++) begin
         cmb_in[ch][0] = cap_q[ch];
         for (int k = 1; k < CIC_ORDER; k++) begin
            cmb_in[ch][k] = c_q[ch][k-1];
         end
`ifdef CIC_ROUND_EN
         rnd[ch] = {c_q[ch][CIC_ORDER-1][ACC_W-1], c_q[ch][CIC_ORDER-1]} + HALF;
         // Adding a positive half LSB can only overflow upward.
         if (rnd[ch][ACC_W -: 2] == 2'b01) begin
            out_d[ch] = MAXP;
         end else begin
            out_d[ch] = DATA_WIDTH'(rnd[ch] >> SH);
         end
`else
         out_d[ch] = DATA_WIDTH'(c_q[ch][CIC_ORDER-1] >> SH);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         stb_q   <= '0;
         valid_q <= 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            x_q[ch]   <= '0;
            cap_q[ch] <= '0;
            out_q[ch] <= '0;
            for (int k = 0; k < CIC_ORDER; k++) begin
               int_q[ch][k] <= '0;
               c_q[ch][k]   <= '0;
               d_q[ch][k]   <= '0;
            end
         end
      end else begin
         cnt_q   <= cnt_d;
         stb_q   <= {stb_q[CIC_ORDER:0], dec_strobe};
         valid_q <= stb_q[CIC_ORDER+1];
         for (int ch = 0; ch < 2; ch++) begin
            x_q[ch] <= {{SH{x_in[ch][DATA_WIDTH-1]}}, x_in[ch]};
            // Integrators wrap freely; the combs cancel the wrap exactly.
            int_q[ch][0] <= int_q[ch][0] + x_q[ch];
            for (int k = 1; k < CIC_ORDER; k++) begin
               int_q[ch][k] <= int_q[ch][k] + int_q[ch][k-1];
            end
            if (stb_q[0]) begin
               cap_q[ch] <= int_q[ch][CIC_ORDER-1];
            end
            for (int k = 0; k < CIC_ORDER; k++) begin
               if (stb_q[k+1]) begin
                  c_q[ch][k] <= cmb_in[ch][k] - d_q[ch][k];
                  d_q[ch][k] <= cmb_in[ch][k];
               end
            end
            if (stb_q[CIC_ORDER+1]) begin
               out_q[ch] <= out_d[ch];
            end
         end
      end
   end

   assign sine_decim_out   = out_q[0];
   assign cosine_decim_out = out_q[1];
   assign decim_valid      = valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: self-checking bench for cic_decimator (R=8, order 3).
// Model: closed-form FIR of the input history, checked every cycle.
module tb_cic_decimator;

   localparam int DW = 12;
   localparam int N  = 3;
   localparam int R  = 8;
   localparam int SH = 9;
   localparam int HN = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [DW-1:0] sin_i = '0;
   logic signed [DW-1:0] cos_i = '0;
   logic [DW-1:0] sin_o;
   logic [DW-1:0] cos_o;
   logic vld;

   int n_chk  = 0;
   int n_fail = 0;

   logic signed [DW-1:0] hs [HN];
   logic signed [DW-1:0] hc [HN];
   int n_edge   = 0;
   bit last_rst = 1'b1;
   bit seen     = 1'b0;
   logic signed [DW-1:0] exp_s = '0;
   logic signed [DW-1:0] exp_c = '0;
   bit ev;
   int t;

   always #5 clk = ~clk;

   cic_decimator #(
      .DATA_WIDTH(DW),
      .CIC_ORDER(N),
      .DECIMATION(R)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sinewave_in(sin_i),
      .cosinewave_in(cos_i),
      .sine_decim_out(sin_o),
      .cosine_decim_out(cos_o),
      .decim_valid(vld)
   );

   task automatic check(string nm, longint got, longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic check_rng(string nm, longint got, longint lo, longint hi);
      n_chk++;
      if (got < lo || got > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, got, lo, hi);
      end
   endtask

   function automatic longint binom(int n, int k);
      longint r = 1;
      for (int j = 1; j <= k; j++) r = r * (n - k + j) / j;
      return r;
   endfunction

   // Value held in the last integrator when decimated sample m is taken:
   // N cascaded running sums of the input, delayed by N+1 cycles.
   function automatic longint cap(bit ch, int m);
      longint acc = 0;
      int top = m * R - N - 1;
      for (int i = 0; i <= top; i++) begin
         acc += (ch ? longint'(hc[i]) : longint'(hs[i])) * binom(top - i + N - 1, N - 1);
      end
      return acc;
   endfunction

   function automatic longint expect_out(bit ch, int m);
      longint y = 0;
      longint q;
      for (int j = 0; j <= N; j++) begin
         y += ((j % 2) ? -1 : 1) * binom(N, j) * cap(ch, m - j);
      end
`ifdef CIC_ROUND_EN
      q = (y + (longint'(1) <<< (SH - 1))) >>> SH;
      if (q > 2047) q = 2047;
`else
      q = y >>> SH;
`endif
      return q;
   endfunction

   always @(posedge clk) begin
      seen = 1'b1;
      last_rst = rst;
      if (rst) begin
         n_edge = 0;
      end else if (n_edge < HN) begin
         hs[n_edge] = sin_i;
         hc[n_edge] = cos_i;
         n_edge++;
      end
   end

   always @(negedge clk) begin
      if (seen) begin
         ev = 1'b0;
         if (last_rst) begin
            exp_s = '0;
            exp_c = '0;
         end else begin
            t  = n_edge - 1;
            ev = (t >= R + N + 1) && ((t - N - 1) % R == 0);
            if (ev) begin
               exp_s = DW'(expect_out(1'b0, (t - N - 1) / R));
               exp_c = DW'(expect_out(1'b1, (t - N - 1) / R));
            end
         end
         check("valid", longint'(vld), longint'(ev));
         check("sine", $signed(sin_o), exp_s);
         check("cosine", $signed(cos_o), exp_c);
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart(logic signed [DW-1:0] s, logic signed [DW-1:0] c);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      sin_i = s;
      cos_i = c;
   endtask

   task automatic wait_valid(string nm, output int k);
      bit found = 1'b0;
      k = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         k++;
         if (vld) found = 1'b1;
      end
      if (!found) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no decim_valid within 40 cycles", nm);
      end
   endtask

   initial begin : drive
      int k;
      int last;
      int nv;
      tick(2);
      rst = 1'b0;
      wait_valid("zero_first", k);
      check("first_valid_edge", k - 1, 12);
      check("zero_sine", $signed(sin_o), 0);
      check("zero_cosine", $signed(cos_o), 0);
      wait_valid("zero_gap", k);
      check("zero_spacing", k, 8);
      wait_valid("zero_gap2", k);
      check("zero_spacing2", k, 8);

      restart(12'sd100, -12'sd37);
      repeat (6) wait_valid("dc", k);
      check("dc_spacing", k, 8);
      check("dc_sine", $signed(sin_o), 100);
      check("dc_cosine", $signed(cos_o), -37);

      wait_valid("rst_pre", k);
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_clr_sine", $signed(sin_o), 0);
      check("rst_clr_valid", longint'(vld), 0);
      wait_valid("rst_post", k);
      check("rst_first_edge", k - 1, 12);
      repeat (4) wait_valid("rst_dc", k);
      check("rst_dc_sine", $signed(sin_o), 100);
      check("rst_dc_cosine", $signed(cos_o), -37);

      restart(12'sd2047, -12'sd2048);
      repeat (6) wait_valid("ext", k);
      check("ext_sine", $signed(sin_o), 2047);
      check("ext_cosine", $signed(cos_o), -2048);

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      last = -1;
      nv = 0;
      for (int i = 0; i < 80; i++) begin
         sin_i = (i % 2 == 0) ? 12'sd1000 : -12'sd1000;
         cos_i = -sin_i;
         tick(1);
         if (vld) begin
            nv++;
            if (last >= 0) check("nyq_spacing", i - last, 8);
            last = i;
            if (nv >= 4) begin
               check_rng("nyq_sine", $signed(sin_o), -1, 1);
               check_rng("nyq_cosine", $signed(cos_o), -1, 1);
            end
         end
      end
      check("nyq_count", nv, 9);

      tick(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
